// File: rtl/pipeline_event_generator_if.sv
// Decode-stage, front-panel button and controller-facing signals of the
// pipeline event generator, bundled for connection between pipeline and block.
interface pipeline_event_generator_if;
    logic       instr_valid;
    logic [7:0] opcode;
    logic       branch_taken;
    logic       resume_btn;
    logic       restart_btn;
    logic       halted;
    logic       flush_detected;
    logic       resume;
    logic       restart;
    logic       fetch_hold;
    logic [7:0] flush_count;

    // Pipeline / front panel side: drives decode info and raw buttons.
    modport master (
        output instr_valid, opcode, branch_taken, resume_btn, restart_btn,
        input  halted, flush_detected, resume, restart, fetch_hold, flush_count
    );

    // Event generator side.
    modport slave (
        input  instr_valid, opcode, branch_taken, resume_btn, restart_btn,
        output halted, flush_detected, resume, restart, fetch_hold, flush_count
    );
endinterface

// File: rtl/pipeline_event_generator.sv
// Pipeline event generator: detects halt opcodes and taken branches in decode,
// conditions the asynchronous resume/restart buttons, and produces registered
// halted / flush / resume / restart / fetch-hold indications for the
// clock/halt controller.
module pipeline_event_generator #(
    parameter logic [7:0] HLT_OPCODE      = 8'hFF,
    parameter int         FLUSH_CYCLES    = 2,
    parameter int         DEBOUNCE_CYCLES = 16
) (
    input logic                        internal_clock,
    input logic                        reset_n,
    pipeline_event_generator_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_HALT,
        ST_RESUME
    } state_t;

    localparam int BTN_RESUME  = 0;
    localparam int BTN_RESTART = 1;

    localparam logic [7:0] DEB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    // ------------------------------------------------------------------
    // Button conditioning (index 0 = resume, 1 = restart)
    // ------------------------------------------------------------------
    logic [1:0] btn_raw;
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] level_q;
    logic [1:0] level_prev_q;
    logic [7:0] deb_cnt_q [2];
    logic [1:0] btn_evt;

    assign btn_raw = {bus.restart_btn, bus.resume_btn};

    // Synchronize, debounce and remember the previous debounced level.
    always_ff @(posedge internal_clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            level_q      <= '0;
            level_prev_q <= '0;
            // NOTE: the small counter array is reset element by element; it is
            // control state, not a storage RAM, so it must start from zero.
            for (int i = 0; i < 2; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge value, which is what makes the 2-FF chain a synchronizer.
            sync1_q      <= btn_raw;
            sync2_q      <= sync1_q;
            level_prev_q <= level_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == level_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DEB_LAST) begin
                    level_q[i]   <= sync2_q[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + 8'd1;
                end
            end
        end
    end

    // Only a rising debounced level counts as a press.
    assign btn_evt = level_q & ~level_prev_q;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [3:0] flush_cnt_q, flush_cnt_d;
    logic [7:0] flush_count_q, flush_count_d;
    logic       restart_d;
    logic       halted_q, flush_q, resume_q, restart_q, hold_q;

    // Next-state, flush timer and flush statistics.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        flush_count_d = flush_count_q;
        restart_d     = 1'b0;

        if (btn_evt[BTN_RESTART]) begin
            // Restart overrides everything, including a same-cycle resume or
            // decode request.
            state_d       = ST_RUN;
            flush_cnt_d   = '0;
            flush_count_d = '0;
            restart_d     = 1'b1;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (bus.instr_valid && bus.opcode == HLT_OPCODE) begin
                        state_d = ST_HALT;
                    end else if (bus.instr_valid && bus.branch_taken) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FLUSH_LOAD;
                        if (flush_count_q != 8'hFF) begin
                            flush_count_d = flush_count_q + 8'd1;
                        end
                    end
                end
                ST_FLUSH: begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                    if (flush_cnt_q <= 4'd1) begin
                        state_d = ST_RUN;
                    end
                end
                ST_HALT: begin
                    if (btn_evt[BTN_RESUME]) begin
                        state_d = ST_RESUME;
                    end
                end
                ST_RESUME: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // State register plus outputs registered from the state being entered.
    always_ff @(posedge internal_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_RUN;
            flush_cnt_q   <= '0;
            flush_count_q <= '0;
            halted_q      <= 1'b0;
            flush_q       <= 1'b0;
            resume_q      <= 1'b0;
            restart_q     <= 1'b0;
            hold_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            flush_count_q <= flush_count_d;
            halted_q      <= (state_d == ST_HALT);
            flush_q       <= (state_d == ST_FLUSH);
            resume_q      <= (state_d == ST_RESUME);
            restart_q     <= restart_d;
            hold_q        <= (state_d != ST_RUN);
        end
    end

    assign bus.halted         = halted_q;
    assign bus.flush_detected = flush_q;
    assign bus.resume         = resume_q;
    assign bus.restart        = restart_q;
    assign bus.fetch_hold     = hold_q;
    assign bus.flush_count    = flush_count_q;

endmodule

// File: tb/tb_pipeline_event_generator.sv
// Testbench for pipeline_event_generator: directed decode/button vectors,
// a per-cycle comparison against a behavioural model, and literal checks at
// the hand-computed points of interest.
module tb_pipeline_event_generator;

    localparam int DEB   = 4;
    localparam int FLUSH = 2;

    logic clk;
    logic reset_n;

    int vectors     = 0;
    int miscompares = 0;

    pipeline_event_generator_if bus_if ();

    pipeline_event_generator #(
        .HLT_OPCODE      (8'hFF),
        .FLUSH_CYCLES    (FLUSH),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .internal_clock (clk),
        .reset_n        (reset_n),
        .bus            (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: a button level flips once the last DEB synchronized
    // samples (raw samples delayed by two edges) all disagree with it.
    // ------------------------------------------------------------------
    bit        m_halted, m_resuming, m_restart;
    int        m_flush_left, m_count;
    bit [31:0] m_res_hist, m_rst_hist;
    bit        m_res_lvl, m_rst_lvl, m_res_evt, m_rst_evt;

    function automatic bit window_differs(input bit [31:0] hist, input bit lvl);
        for (int j = 2; j <= DEB + 1; j++) begin
            if (hist[j] == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_halted = 0; m_resuming = 0; m_restart = 0;
            m_flush_left = 0; m_count = 0;
            m_res_hist = '0; m_rst_hist = '0;
            m_res_lvl = 0; m_rst_lvl = 0; m_res_evt = 0; m_rst_evt = 0;
        end else begin
            m_restart = 0;
            if (m_rst_evt) begin
                m_halted = 0; m_resuming = 0; m_flush_left = 0; m_count = 0;
                m_restart = 1;
            end else if (m_resuming) begin
                m_resuming = 0;
            end else if (m_halted) begin
                if (m_res_evt) begin
                    m_halted   = 0;
                    m_resuming = 1;
                end
            end else if (m_flush_left > 0) begin
                m_flush_left--;
            end else if (bus_if.instr_valid && bus_if.opcode == 8'hFF) begin
                m_halted = 1;
            end else if (bus_if.instr_valid && bus_if.branch_taken) begin
                m_flush_left = FLUSH;
                if (m_count < 255) m_count++;
            end

            m_res_hist = {m_res_hist[30:0], bus_if.resume_btn};
            m_rst_hist = {m_rst_hist[30:0], bus_if.restart_btn};
            m_res_evt = 0;
            m_rst_evt = 0;
            if (window_differs(m_res_hist, m_res_lvl)) begin
                m_res_lvl = !m_res_lvl;
                m_res_evt = m_res_lvl;
            end
            if (window_differs(m_rst_hist, m_rst_lvl)) begin
                m_rst_lvl = !m_rst_lvl;
                m_rst_evt = m_rst_lvl;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(posedge clk) begin
        #1;
        check("m_halted",  {7'd0, bus_if.halted},         {7'd0, m_halted});
        check("m_flush",   {7'd0, bus_if.flush_detected}, {7'd0, (m_flush_left > 0)});
        check("m_resume",  {7'd0, bus_if.resume},         {7'd0, m_resuming});
        check("m_restart", {7'd0, bus_if.restart},        {7'd0, m_restart});
        check("m_hold",    {7'd0, bus_if.fetch_hold},
              {7'd0, (m_halted || m_resuming || m_flush_left > 0)});
        check("m_count",   bus_if.flush_count,            8'(m_count));
    end

    // Advance n edges and settle just after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic decode(input logic iv, input logic [7:0] op, input logic bt);
        bus_if.instr_valid  = iv;
        bus_if.opcode       = op;
        bus_if.branch_taken = bt;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_halted"}, {7'd0, bus_if.halted},         8'd0);
        check({tag, "_flush"},  {7'd0, bus_if.flush_detected}, 8'd0);
        check({tag, "_resume"}, {7'd0, bus_if.resume},         8'd0);
        check({tag, "_restart"},{7'd0, bus_if.restart},        8'd0);
        check({tag, "_hold"},   {7'd0, bus_if.fetch_hold},     8'd0);
        check({tag, "_count"},  bus_if.flush_count,            8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t, limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        decode(1'b0, 8'h00, 1'b0);
        bus_if.resume_btn  = 1'b0;
        bus_if.restart_btn = 1'b0;
        #23;
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        step(2);

        // Single taken branch: two flush cycles, count 1.
        decode(1'b1, 8'h12, 1'b1);
        step(1);
        check("br_flush0", {7'd0, bus_if.flush_detected}, 8'd1);
        check("br_hold0",  {7'd0, bus_if.fetch_hold},     8'd1);
        check("br_count",  bus_if.flush_count,            8'd1);
        decode(1'b0, 8'h00, 1'b0);
        step(1);
        check("br_flush1", {7'd0, bus_if.flush_detected}, 8'd1);
        step(1);
        check("br_flush2", {7'd0, bus_if.flush_detected}, 8'd0);
        check("br_hold2",  {7'd0, bus_if.fetch_hold},     8'd0);

        // Halt opcode with branch: halt wins, decode ignored while halted.
        decode(1'b1, 8'hFF, 1'b1);
        step(1);
        check("halt_halted", {7'd0, bus_if.halted},         8'd1);
        check("halt_flush",  {7'd0, bus_if.flush_detected}, 8'd0);
        check("halt_count",  bus_if.flush_count,            8'd1);
        step(20);
        check("halt_stay",   {7'd0, bus_if.halted},         8'd1);
        check("halt_count2", bus_if.flush_count,            8'd1);
        decode(1'b0, 8'h00, 1'b0);

        // Three-cycle glitch on resume: filtered out.
        bus_if.resume_btn = 1'b1;
        step(3);
        bus_if.resume_btn = 1'b0;
        step(15);
        check("glitch_halted", {7'd0, bus_if.halted}, 8'd1);

        // Held resume: pulse in the cycle after edge 6, exactly once.
        bus_if.resume_btn = 1'b1;
        step(6);
        check("res_pre_pulse",  {7'd0, bus_if.resume}, 8'd0);
        check("res_pre_halted", {7'd0, bus_if.halted}, 8'd1);
        step(1);
        check("res_pulse",      {7'd0, bus_if.resume}, 8'd1);
        check("res_halted",     {7'd0, bus_if.halted}, 8'd0);
        step(1);
        check("res_after",      {7'd0, bus_if.resume},     8'd0);
        check("res_run_hold",   {7'd0, bus_if.fetch_hold}, 8'd0);
        step(20);
        bus_if.resume_btn = 1'b0;
        step(10);

        // Continuous branches: flush_count saturates at FF.
        decode(1'b1, 8'h00, 1'b1);
        step(950);
        check("sat_count", bus_if.flush_count, 8'hFF);
        decode(1'b0, 8'h00, 1'b0);
        step(3);
        decode(1'b1, 8'hFF, 1'b0);
        step(1);
        decode(1'b0, 8'h00, 1'b0);
        check("sat_halted", {7'd0, bus_if.halted}, 8'd1);

        // Restart press clears halt and statistics.
        bus_if.restart_btn = 1'b1;
        step(6);
        check("rst_pre_pulse", {7'd0, bus_if.restart}, 8'd0);
        step(1);
        check("rst_pulse",  {7'd0, bus_if.restart},    8'd1);
        check("rst_count",  bus_if.flush_count,        8'd0);
        check("rst_halted", {7'd0, bus_if.halted},     8'd0);
        check("rst_hold",   {7'd0, bus_if.fetch_hold}, 8'd0);
        step(1);
        check("rst_after",  {7'd0, bus_if.restart},    8'd0);
        bus_if.restart_btn = 1'b0;
        step(10);

        // Resume press outside HALT is discarded, not queued.
        bus_if.resume_btn = 1'b1;
        step(10);
        bus_if.resume_btn = 1'b0;
        step(8);
        decode(1'b1, 8'hFF, 1'b0);
        step(1);
        decode(1'b0, 8'h00, 1'b0);
        step(10);
        check("noqueue_halted", {7'd0, bus_if.halted}, 8'd1);
        bus_if.restart_btn = 1'b1;
        step(12);
        bus_if.restart_btn = 1'b0;
        step(8);

        // Asynchronous reset in the middle of a flush.
        decode(1'b1, 8'h00, 1'b1);
        step(1);
        decode(1'b0, 8'h00, 1'b0);
        check("mid_flush_pre", {7'd0, bus_if.flush_detected}, 8'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("flush_arst");
        @(negedge clk);
        reset_n = 1'b1;
        step(1);
        check("flush_rel_hold", {7'd0, bus_if.fetch_hold}, 8'd0);

        // Asynchronous reset while halted.
        decode(1'b1, 8'hFF, 1'b0);
        step(1);
        decode(1'b0, 8'h00, 1'b0);
        check("mid_halt_pre", {7'd0, bus_if.halted}, 8'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("halt_arst");
        @(negedge clk);
        reset_n = 1'b1;
        step(1);
        check("halt_rel_hold",   {7'd0, bus_if.fetch_hold}, 8'd0);
        check("halt_rel_halted", {7'd0, bus_if.halted},     8'd0);
        step(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
